serial_rx_frame_ctrl: RTL

Oversampling receive controller for the odd-parity 11-bit serial frame: 1 start bit (0), 8 data bits LSB first, 1 odd-parity bit, 1 stop bit (1).
- Sequences bit timing with a mid-bit sampling FSM.
- Validates start, parity and stop bits.
- Buffers good bytes in a small FIFO with a valid/ready handshake toward the consumer.
- Sits between the raw line input and byte-level consumers; reports parity, framing and overrun events.

---
 rtl/serial_rx_frame_ctrl_if.sv | 10 +
 rtl/serial_rx_frame_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_rx_frame_ctrl_if.sv
// Byte handshake between the serial receive controller and its consumer.
// The master side presents the FIFO head byte; the slave side accepts it with i_ready.
interface serial_rx_frame_ctrl_if;
  logic [7:0] o_byte;
  logic       o_valid;
  logic       i_ready;

  modport master (output o_byte, output o_valid, input i_ready);
  modport slave  (input o_byte, input o_valid, output i_ready);
endinterface

// File: rtl/serial_rx_frame_ctrl.sv
// Oversampling receiver for 11-bit odd-parity frames with a small byte FIFO.
// Define RX_ERR_CNT_EN to add saturating parity/framing error counters.
module serial_rx_frame_ctrl #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int LVL_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_data,
  serial_rx_frame_ctrl_if.master rx,
  output logic             o_parity_err,
  output logic             o_frame_err,
  output logic             o_overrun,
  output logic             o_busy,
  output logic [LVL_W-1:0] o_level
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0]       o_perr_cnt,
  output logic [7:0]       o_ferr_cnt
`endif
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0]    BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]    HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          push_q, push_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic [1:0]    sync_q;
  logic          ln;
  logic          bit_end, half_end;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], i_data};
  end

  assign ln       = sync_q[1];
  assign bit_end  = (timer_q == BIT_LAST);
  assign half_end = (timer_q == HALF_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      push_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      push_q  <= push_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Start is qualified at half a bit; every later sample is one full bit on, i.e. mid-bit.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    push_d  = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (!ln) state_d = START;
      end
      START: begin
        timer_d = timer_q + 1'b1;
        if (half_end) begin
          timer_d = '0;
          idx_d   = '0;
          state_d = ln ? IDLE : DATA;
        end
      end
      DATA: begin
        timer_d = timer_q + 1'b1;
        if (bit_end) begin
          timer_d        = '0;
          shreg_d[idx_q] = ln;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        timer_d = timer_q + 1'b1;
        if (bit_end) begin
          timer_d = '0;
          par_d   = ln;
          state_d = STOP;
        end
      end
      STOP: begin
        timer_d = timer_q + 1'b1;
        if (bit_end) begin
          timer_d = '0;
          if (ln) begin
            if (^{shreg_q, par_q}) push_d = 1'b1;
            else                   perr_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK_WAIT;
          end
        end
      end
      BRK_WAIT: begin
        timer_d = '0;
        if (ln) state_d = IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != IDLE);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic             full, empty, pop, wr_en;

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign pop   = !empty && rx.i_ready;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign wr_en = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= shreg_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign rx.o_byte  = mem[rd_ptr];
  assign rx.o_valid = !empty;
  assign o_level    = level;
  assign o_overrun  = push_q && full && !pop;

`ifdef RX_ERR_CNT_EN
  logic [7:0] perr_cnt, ferr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perr_cnt <= '0;
      ferr_cnt <= '0;
    end else begin
      if (perr_q && perr_cnt != 8'hFF) perr_cnt <= perr_cnt + 8'd1;
      if (ferr_q && ferr_cnt != 8'hFF) ferr_cnt <= ferr_cnt + 8'd1;
    end
  end

  assign o_perr_cnt = perr_cnt;
  assign o_ferr_cnt = ferr_cnt;
`endif

endmodule
